// File: rtl/vm_pkg.sv
// vm_pkg: definitions shared by the vending-machine controller files.
//   state_e       : controller states (IDLE, COLLECT, DISPENSE, CHANGE)
//   COIN5_VAL     : credit value of the small coin
//   COIN10_VAL    : credit value of the large coin
//   PRICE_DEFAULT : default item price in credit units
//   max_int       : elaboration-time helper used to size the shared tick counter
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_e;

  localparam int COIN5_VAL     = 5;
  localparam int COIN10_VAL    = 10;
  localparam int PRICE_DEFAULT = 25;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// tick_counter: counts 2 Hz tick enables and flags the tick that reaches a
// programmable terminal count. Shared by the inactivity timeout and the
// dispense hold time, so the owner clears it on every phase change.
// Ports:
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   clear_i    : synchronous clear (phase entry / coin activity)
//   en_i       : counting enabled in the current phase
//   tick_i     : one-cycle 2 Hz enable
//   terminal_i : terminal count for the current phase
//   done_o     : high in the cycle whose tick makes the count reach terminal_i
module tick_counter #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic         tick_i,
  input  logic [W-1:0] terminal_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W:0]   count_inc;

  assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};

  // done does not look at clear_i: the owner derives clear_i from its own
  // next state, which in turn depends on done_o.
  assign done_o = en_i && tick_i && (count_inc >= {1'b0, terminal_i});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i && tick_i && !count_inc[W]) begin
      count_q <= count_inc[W-1:0];
    end
  end

endmodule

// File: rtl/vm_ctrl_fsm.sv
// vm_ctrl_fsm: vending-machine transaction controller. Accumulates coin
// credit, dispenses when credit covers PRICE, returns change, and refunds on
// cancel or after TIMEOUT_TICKS ticks of coin inactivity. tick_i is a 2 Hz
// enable in the clk_in domain, not a clock.
// Optional build macro: SALES_AUDIT_EN adds the 16-bit sales_cnt_o counter.
// Ports:
//   clk_in         : system clock
//   reset          : asynchronous active-low reset
//   tick_i         : 2 Hz one-cycle enable
//   coin5_i        : 5-unit coin pulse
//   coin10_i       : 10-unit coin pulse
//   cancel_i       : customer cancel pulse
//   credit_o       : current credit
//   dispense_o     : vend actuator
//   change_valid_o : one-cycle strobe qualifying change_amt_o
//   change_amt_o   : change or refund amount
//   sales_cnt_o    : dispense count, wraps at 16 bits (SALES_AUDIT_EN only)
//   busy_o         : high in any state except IDLE
module vm_ctrl_fsm
  import vm_pkg::*;
#(
  parameter int PRICE         = PRICE_DEFAULT,
  parameter int CREDIT_W      = 7,
  parameter int TIMEOUT_TICKS = 20,
  parameter int DISP_TICKS    = 4
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                tick_i,
  input  logic                coin5_i,
  input  logic                coin10_i,
  input  logic                cancel_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                dispense_o,
  output logic                change_valid_o,
  output logic [CREDIT_W-1:0] change_amt_o,
`ifdef SALES_AUDIT_EN
  output logic [15:0]         sales_cnt_o,
`endif
  output logic                busy_o
);

  localparam int TW = $clog2(max_int(TIMEOUT_TICKS, DISP_TICKS) + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] COIN5_C  = CREDIT_W'(COIN5_VAL);
  localparam logic [CREDIT_W-1:0] COIN10_C = CREDIT_W'(COIN10_VAL);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                dispense_q;
  logic                change_valid_q;
  logic                busy_q;

  logic                coin_any;
  logic                accepting;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] credit_add;

  logic                tmr_clear;
  logic                tmr_en;
  logic                tmr_done;
  logic [TW-1:0]       tmr_term;

  assign coin_any  = coin5_i || coin10_i;
  assign accepting = (state_q == IDLE) || (state_q == COLLECT);

  // Both coins in one cycle are both credited.
  always_comb begin
    coin_val = '0;
    if (coin5_i) begin
      coin_val = coin_val + COIN5_C;
    end
    if (coin10_i) begin
      coin_val = coin_val + COIN10_C;
    end
  end

  assign sum        = {1'b0, credit_q} + {1'b0, coin_val};
  assign credit_add = sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];

  // Timer is reset on every phase change and on coin activity in COLLECT;
  // it only counts in the two timed phases.
  assign tmr_clear = (state_d != state_q) || ((state_q == COLLECT) && coin_any);
  assign tmr_en    = (state_q == COLLECT) || (state_q == DISPENSE);
  assign tmr_term  = (state_q == DISPENSE) ? TW'(DISP_TICKS) : TW'(TIMEOUT_TICKS);

  tick_counter #(
    .W (TW)
  ) u_tick_counter (
    .clk_i      (clk_in),
    .rst_ni     (reset),
    .clear_i    (tmr_clear),
    .en_i       (tmr_en),
    .tick_i     (tick_i),
    .terminal_i (tmr_term),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    unique case (state_q)
      IDLE: begin
        if (coin_any) begin
          credit_d = credit_add;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        credit_d = credit_add;
        // Reaching the price beats a simultaneous cancel; a coin in the same
        // cycle as the timeout tick restarts the inactivity window.
        if (credit_add >= PRICE_C) begin
          state_d  = DISPENSE;
          change_d = credit_add - PRICE_C;
        end else if (cancel_i || (tmr_done && !coin_any)) begin
          state_d  = CHANGE;
          change_d = credit_add;
        end
      end
      DISPENSE: begin
        if (tmr_done) begin
          state_d = CHANGE;
        end
      end
      CHANGE: begin
        state_d  = IDLE;
        credit_d = '0;
        change_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SALES_AUDIT_EN
  logic [15:0] sales_q;
  assign sales_cnt_o = sales_q;
`endif

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SALES_AUDIT_EN
      sales_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      dispense_q     <= (state_d == DISPENSE);
      change_valid_q <= (state_d == CHANGE);
      busy_q         <= (state_d != IDLE);
`ifdef SALES_AUDIT_EN
      if ((state_q != DISPENSE) && (state_d == DISPENSE)) begin
        sales_q <= sales_q + 16'd1;
      end
`endif
    end
  end

  assign credit_o       = credit_q;
  assign change_amt_o   = change_q;
  assign dispense_o     = dispense_q;
  assign change_valid_o = change_valid_q;
  assign busy_o         = busy_q;

  // Saturation is only a safety net; legal parameters never reach it.
  a_credit_no_overflow: assert property (
    @(posedge clk_in) disable iff (!reset)
    (accepting && coin_any) |-> !sum[CREDIT_W]
  );

endmodule

// File: tb/tb_vm_ctrl_fsm.sv
module tb_vm_ctrl_fsm;

  localparam int PRICE = 25;
  localparam int CW    = 7;
  localparam int TO    = 20;
  localparam int DT    = 4;

  // Model phases (bench-local numbering)
  localparam int P_IDLE = 0;
  localparam int P_COL  = 1;
  localparam int P_DISP = 2;
  localparam int P_CHG  = 3;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          tick   = 1'b0;
  logic          c5     = 1'b0;
  logic          c10    = 1'b0;
  logic          cancel = 1'b0;
  logic [CW-1:0] credit;
  logic [CW-1:0] amt;
  logic          disp;
  logic          cv;
  logic          busy;
`ifdef SALES_AUDIT_EN
  logic [15:0]   sales;
`endif

  always #5 clk = ~clk;

  vm_ctrl_fsm #(
    .PRICE         (PRICE),
    .CREDIT_W      (CW),
    .TIMEOUT_TICKS (TO),
    .DISP_TICKS    (DT)
  ) dut (
    .clk_in         (clk),
    .reset          (rst_n),
    .tick_i         (tick),
    .coin5_i        (c5),
    .coin10_i       (c10),
    .cancel_i       (cancel),
    .credit_o       (credit),
    .dispense_o     (disp),
    .change_valid_o (cv),
    .change_amt_o   (amt),
`ifdef SALES_AUDIT_EN
    .sales_cnt_o    (sales),
`endif
    .busy_o         (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase  = P_IDLE;
  int m_credit = 0;
  int m_ticks  = 0;
  int m_change = 0;
  int m_sales  = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = P_IDLE; m_credit = 0; m_ticks = 0; m_change = 0; m_sales = 0;
      end else begin
        int coins;
        coins = (c5 ? 5 : 0) + (c10 ? 10 : 0);
        case (m_phase)
          P_IDLE: begin
            if (coins > 0) begin
              m_credit = m_credit + coins;
              m_phase  = P_COL;
              m_ticks  = 0;
            end
          end
          P_COL: begin
            if (coins > 0) begin
              m_credit = (m_credit + coins > 127) ? 127 : m_credit + coins;
              m_ticks  = 0;
            end else if (tick) begin
              m_ticks++;
            end
            if (m_credit >= PRICE) begin
              m_phase  = P_DISP;
              m_change = m_credit - PRICE;
              m_ticks  = 0;
              m_sales  = (m_sales + 1) % 65536;
            end else if (cancel || m_ticks == TO) begin
              m_phase  = P_CHG;
              m_change = m_credit;
            end
          end
          P_DISP: begin
            if (tick) m_ticks++;
            if (m_ticks == DT) m_phase = P_CHG;
          end
          default: begin
            m_phase  = P_IDLE;
            m_credit = 0;
            m_change = 0;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int strobes    = 0;
  int last_amt   = -1;
  int disp_ticks = 0;
  int disp_cyc   = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_credit",   credit, m_credit);
      chk("cyc_dispense", disp,   (m_phase == P_DISP) ? 1 : 0);
      chk("cyc_chg_vld",  cv,     (m_phase == P_CHG)  ? 1 : 0);
      chk("cyc_chg_amt",  amt,    m_change);
      chk("cyc_busy",     busy,   (m_phase != P_IDLE) ? 1 : 0);
`ifdef SALES_AUDIT_EN
      chk("cyc_sales",    sales,  m_sales);
`endif
      if (cv === 1'b1) begin
        strobes++;
        last_amt = int'(amt);
        $display("strobe #%0d: change_amt=%0d t=%0t", strobes, amt, $time);
      end
      if (disp === 1'b1) begin
        disp_cyc++;
        if (tick) disp_ticks++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Every task starts and ends 2 time units after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input bit a5, input bit a10, input bit k, input bit t);
    c5 = a5; c10 = a10; cancel = k; tick = t;
    @(posedge clk);
    #2;
    c5 = 1'b0; c10 = 1'b0; cancel = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      drive(0, 0, 0, 1);
      cyc(2);
    end
  endtask

  int s0, d0, dc0;

  initial begin
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_credit", credit, 0);
    chk("rst_busy",   busy,   0);
    chk("rst_disp",   disp,   0);
    chk("rst_cv",     cv,     0);
    chk("rst_amt",    amt,    0);
    rst_n = 1'b1;
    cyc(2);

    // Exact pay: 10, 10, 5
    s0 = strobes; d0 = disp_ticks;
    drive(0, 1, 0, 0); chk("exact_credit_10", credit, 10);
    drive(0, 1, 0, 0); chk("exact_credit_20", credit, 20);
    drive(1, 0, 0, 0); chk("exact_credit_25", credit, 25);
    chk("exact_disp_on", disp, 1);
    ticks(DT - 1);     chk("exact_disp_hold", disp, 1);
    ticks(1);
    chk("exact_strobes",    strobes - s0, 1);
    chk("exact_amt",        last_amt, 0);
    chk("exact_disp_ticks", disp_ticks - d0, DT);
    chk("exact_idle",       busy, 0);
    chk("exact_credit_clr", credit, 0);

    // Overpay: 10 x 3
    s0 = strobes;
    drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    chk("over_credit_30", credit, 30);
    chk("over_amt_held",  amt, 5);
    ticks(DT);
    chk("over_strobes", strobes - s0, 1);
    chk("over_amt",     last_amt, 5);

    // Timeout refund of 5
    s0 = strobes; dc0 = disp_cyc;
    drive(1, 0, 0, 0);
    ticks(TO - 1);
    chk("to_busy_19", busy, 1);
    chk("to_no_strobe_19", strobes - s0, 0);
    ticks(1);
    chk("to_strobes", strobes - s0, 1);
    chk("to_amt", last_amt, 5);
    chk("to_no_dispense", disp_cyc - dc0, 0);

    // Coin part-way through restarts the inactivity window
    s0 = strobes;
    drive(1, 0, 0, 0);
    ticks(10);
    drive(1, 0, 0, 0);
    ticks(TO - 1);
    chk("to2_no_strobe", strobes - s0, 0);
    ticks(1);
    chk("to2_amt", last_amt, 10);

    // Simultaneous coins, then cancel with a coin
    s0 = strobes;
    drive(1, 1, 0, 0); chk("sim_credit_15", credit, 15);
    drive(1, 0, 1, 0);
    chk("cancel_cv", cv, 1);
    cyc(2);
    chk("cancel_strobes", strobes - s0, 1);
    chk("cancel_amt", last_amt, 20);

    // Coins rejected during DISPENSE
    s0 = strobes;
    drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(1, 0, 0, 0);
    drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    chk("rej_credit", credit, 25);
    chk("rej_amt",    amt, 0);
    ticks(DT);
    chk("rej_final_amt", last_amt, 0);
    chk("rej_strobes", strobes - s0, 1);

    // Cancel in IDLE is ignored
    s0 = strobes;
    drive(0, 0, 1, 0);
    cyc(2);
    chk("idle_cancel_busy", busy, 0);
    chk("idle_cancel_strb", strobes - s0, 0);

    // Cancel with price reached: dispense wins
    s0 = strobes;
    drive(0, 1, 0, 0); drive(0, 1, 0, 0); drive(1, 0, 1, 0);
    chk("win_disp", disp, 1);
    chk("win_cv",   cv, 0);
    ticks(DT);
    chk("win_strobes", strobes - s0, 1);
    chk("win_amt", last_amt, 0);
`ifdef SALES_AUDIT_EN
    chk("sales_total", sales, 4);
`endif

    // Asynchronous reset mid-COLLECT
    drive(1, 1, 0, 0);
    chk("ar_credit_15", credit, 15);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_credit", credit, 0);
    chk("ar_busy",   busy, 0);
    chk("ar_disp",   disp, 0);
    chk("ar_cv",     cv, 0);
    chk("ar_amt",    amt, 0);
`ifdef SALES_AUDIT_EN
    chk("ar_sales",  sales, 0);
`endif
    s0 = strobes;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("ar_no_strobe", strobes - s0, 0);

    // Operation resumes after reset
    drive(0, 1, 0, 0);
    chk("post_credit", credit, 10);
    drive(0, 0, 1, 0);
    cyc(2);
    chk("post_amt", last_amt, 10);
    chk("post_idle", busy, 0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
